pipeline_if_fetch_queue: RTL and testbench

PIPELINE_IF_FETCH_QUEUE -- requirements
Module: pipeline_if_fetch_queue

---
 rtl/pipeline_pkg.sv | 24 ++
 rtl/pipeline_fetch_fifo.sv | 64 ++++++
 rtl/pipeline_if_fetch_queue.sv | 81 ++++++++
 tb/tb_pipeline_if_fetch_queue.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared definitions for the instruction-fetch front end: next-PC modes,
// the NOP encoding and default vector addresses.
package pipeline_pkg;

  typedef enum logic [2:0] {
    PC_SEQ    = 3'd0,
    PC_BRANCH = 3'd1,
    PC_JUMP   = 3'd2,
    PC_JR     = 3'd3,
    PC_ILLOP  = 3'd4,
    PC_XADR   = 3'd5
  } pc_src_e;

  localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;
  localparam logic [31:0] ILLOP_PC_DEF = 32'h8000_0004;
  localparam logic [31:0] XADR_PC_DEF  = 32'h8000_0008;

  // Bit 31 is the supervisor flag: it is held and never receives the carry.
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return {pc[31], pc[30:0] + 31'd4};
  endfunction

endpackage

// File: rtl/pipeline_fetch_fifo.sv
// Circular fetch queue with push, pop, synchronous clear and occupancy count.
// Pointers wrap modulo DEPTH, so DEPTH need not be a power of two.
module pipeline_fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       clear,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr, rptr;
  logic             push_eff, pop_eff;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign pop_eff  = pop && !empty;
  assign push_eff = push && (!full || pop_eff);
  assign rdata    = mem[rptr];

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (clear) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_eff) wptr <= wrap_inc(wptr);
      if (pop_eff)  rptr <= wrap_inc(rptr);
      case ({push_eff, pop_eff})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; the count gates every read,
  // and leaving it unreset lets synthesis map it onto plain RAM/flops.
  always_ff @(posedge clk) begin
    if (push_eff && !clear) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/pipeline_if_fetch_queue.sv
// Instruction-fetch stage: PC register, next-PC selection and a fetch queue
// that decouples ROM fetch from the ID stage.
module pipeline_if_fetch_queue
  import pipeline_pkg::*;
#(
  parameter int          ROM_AW   = 7,
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] ILLOP_PC = ILLOP_PC_DEF,
  parameter logic [31:0] XADR_PC  = XADR_PC_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [2:0]                 pc_src,
  input  logic                       alu_out,
  input  logic [25:0]                jt,
  input  logic [31:0]                con_ba,
  input  logic [31:0]                databus_a,
  output logic [ROM_AW-1:0]          rom_addr,
  input  logic [31:0]                rom_data,
  input  logic                       id_ready,
  output logic                       ifid_valid,
  output logic [31:0]                ifid_pc4,
  output logic [31:0]                ifid_instr,
  output logic [$clog2(DEPTH+1)-1:0] q_count
);

  logic [31:0] pc, pc4, target, pc_next;
  logic        redirect, fetch, pop, full, empty;
  logic [63:0] head;

  assign pc4      = pc_plus4(pc);
  assign rom_addr = pc[ROM_AW+1:2];

  assign ifid_valid = !empty;
  assign ifid_pc4   = ifid_valid ? head[63:32] : 32'h0;
  assign ifid_instr = ifid_valid ? head[31:0]  : NOP_INSTR;

  assign pop   = ifid_valid && id_ready;
  assign fetch = !redirect && (!full || pop);

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    redirect = 1'b0;
    target   = pc4;
    case (pc_src)
      PC_BRANCH: begin redirect = alu_out; target = con_ba; end
      PC_JUMP:   begin redirect = 1'b1; target = {ifid_pc4[31:28], jt, 2'b00}; end
      PC_JR:     begin redirect = 1'b1; target = databus_a; end
      PC_ILLOP:  begin redirect = 1'b1; target = ILLOP_PC; end
      PC_XADR:   begin redirect = 1'b1; target = XADR_PC; end
      default:   begin redirect = 1'b0; target = pc4; end
    endcase
  end

  assign pc_next = redirect ? target : (fetch ? pc4 : pc);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pc <= RESET_PC;
    else        pc <= pc_next;
  end

  // Clear dominates inside the queue, so a pop coinciding with a redirect is dropped.
  pipeline_fetch_fifo #(
    .WIDTH (64),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fetch),
    .pop   (pop),
    .clear (redirect),
    .wdata ({pc4, rom_data}),
    .rdata (head),
    .count (q_count),
    .full  (full),
    .empty (empty)
  );

endmodule

// File: tb/tb_pipeline_if_fetch_queue.sv
// Directed bench for the fetch queue: a queue-based reference model checked
// every cycle, plus hand-computed expectations at the key scenarios.
`timescale 1ns/1ps
module tb_pipeline_if_fetch_queue;

  localparam int ROM_AW = 7;
  localparam int DEPTH  = 4;
  localparam int CW     = $clog2(DEPTH+1);
  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam logic [31:0] ILL_PC = 32'h8000_0004;
  localparam logic [31:0] XAD_PC = 32'h8000_0008;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [2:0]        pc_src = '0;
  logic              alu_out = 1'b0;
  logic [25:0]       jt = '0;
  logic [31:0]       con_ba = '0, databus_a = '0;
  logic [ROM_AW-1:0] rom_addr;
  logic [31:0]       rom_data;
  logic              id_ready = 1'b1;
  logic              ifid_valid;
  logic [31:0]       ifid_pc4, ifid_instr;
  logic [CW-1:0]     q_count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [ROM_AW-1:0] a);
    return 32'hA000_0000 | (32'(a) << 8) | 32'(a);
  endfunction

  assign rom_data = rom_word(rom_addr);

  pipeline_if_fetch_queue #(.ROM_AW(ROM_AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .pc_src(pc_src), .alu_out(alu_out), .jt(jt),
    .con_ba(con_ba), .databus_a(databus_a), .rom_addr(rom_addr),
    .rom_data(rom_data), .id_ready(id_ready), .ifid_valid(ifid_valid),
    .ifid_pc4(ifid_pc4), .ifid_instr(ifid_instr), .q_count(q_count)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference model: a queue of {pc4, instr} entries and a PC.
  logic [63:0] mq[$];
  logic [31:0] mpc = RST_PC;
  logic [31:0] m_tgt, m_head_pc4, m_inc;
  bit          m_redir, m_pop, m_push;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mq.delete();
      mpc = RST_PC;
    end else begin
      m_head_pc4 = (mq.size() != 0) ? mq[0][63:32] : 32'h0;
      m_inc = (mpc & 32'h8000_0000) | ((mpc + 32'd4) & 32'h7FFF_FFFF);
      m_redir = 1'b1;
      m_tgt = 32'h0;
      case (pc_src)
        3'd1: begin m_redir = alu_out; m_tgt = con_ba; end
        3'd2: m_tgt = {m_head_pc4[31:28], jt, 2'b00};
        3'd3: m_tgt = databus_a;
        3'd4: m_tgt = ILL_PC;
        3'd5: m_tgt = XAD_PC;
        default: m_redir = 1'b0;
      endcase
      if (m_redir) begin
        mq.delete();
        mpc = m_tgt;
      end else begin
        m_pop  = (mq.size() != 0) && id_ready;
        m_push = (mq.size() < DEPTH) || m_pop;
        if (m_pop) void'(mq.pop_front());
        if (m_push) begin
          mq.push_back({m_inc, rom_word(mpc[ROM_AW+1:2])});
          mpc = m_inc;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (reset === 1'b1) begin
      check("m_count", 64'(q_count), 64'(mq.size()));
      check("m_valid", 64'(ifid_valid), 64'(mq.size() != 0));
      check("m_pc4", 64'(ifid_pc4), (mq.size() != 0) ? 64'(mq[0][63:32]) : 64'h0);
      check("m_instr", 64'(ifid_instr), (mq.size() != 0) ? 64'(mq[0][31:0]) : 64'h0);
      check("m_rom_addr", 64'(rom_addr), 64'(mpc[ROM_AW+1:2]));
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #3;
    check("rst_count", 64'(q_count), 64'h0);
    check("rst_valid", 64'(ifid_valid), 64'h0);
    check("rst_pc4", 64'(ifid_pc4), 64'h0);
    check("rst_instr", 64'(ifid_instr), 64'h0);
    check("rst_rom_addr", 64'(rom_addr), 64'h0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    check("first_pc4", 64'(ifid_pc4), 64'h8000_0004);
    check("first_instr", 64'(ifid_instr), 64'(rom_word(7'd0)));
    tick();
    check("second_pc4", 64'(ifid_pc4), 64'h8000_0008);

    // Stall straight out of reset: queue saturates, PC parks at RESET_PC+16.
    reset = 1'b0;
    id_ready = 1'b0;
    tick();
    reset = 1'b1;
    repeat (6) tick();
    check("stall_count", 64'(q_count), 64'd4);
    check("stall_rom_addr", 64'(rom_addr), 64'd4);
    check("stall_head", 64'(ifid_pc4), 64'h8000_0004);
    id_ready = 1'b1;
    tick();
    check("drain_head", 64'(ifid_pc4), 64'h8000_0008);
    repeat (3) tick();

    // Register jump.
    pc_src = 3'd3;
    databus_a = 32'h0040_0010;
    tick();
    check("jr_count", 64'(q_count), 64'h0);
    check("jr_valid", 64'(ifid_valid), 64'h0);
    check("jr_rom_addr", 64'(rom_addr), 64'd4);
    pc_src = 3'd0;
    id_ready = 1'b0;
    tick();
    check("jr_pc4", 64'(ifid_pc4), 64'h0040_0014);
    tick();
    tick();
    check("three_queued", 64'(q_count), 64'd3);

    // Taken branch with a simultaneous pop: queue flushed.
    pc_src = 3'd1;
    alu_out = 1'b1;
    con_ba = 32'h8000_0040;
    id_ready = 1'b1;
    tick();
    check("br_count", 64'(q_count), 64'h0);
    check("br_valid", 64'(ifid_valid), 64'h0);
    check("br_instr", 64'(ifid_instr), 64'h0);
    pc_src = 3'd0;
    alu_out = 1'b0;
    id_ready = 1'b0;
    tick();
    check("br_pc4", 64'(ifid_pc4), 64'h8000_0044);

    pc_src = 3'd1;
    tick();
    check("br_not_taken", 64'(q_count), 64'd2);

    // Jump uses the head entry's PC+4 upper nibble.
    pc_src = 3'd2;
    jt = 26'h000_0123;
    tick();
    check("jump_rom_addr", 64'(rom_addr), 64'h23);
    check("jump_count", 64'(q_count), 64'h0);
    pc_src = 3'd4;
    tick();
    check("illop_rom_addr", 64'(rom_addr), 64'd1);
    pc_src = 3'd5;
    tick();
    check("xadr_rom_addr", 64'(rom_addr), 64'd2);
    pc_src = 3'd6;
    id_ready = 1'b1;
    tick();
    pc_src = 3'd7;
    tick();

    // Carry out of bit 30 must not reach the supervisor bit.
    pc_src = 3'd3;
    databus_a = 32'hFFFF_FFFC;
    tick();
    pc_src = 3'd0;
    id_ready = 1'b0;
    tick();
    check("wrap_pc4", 64'(ifid_pc4), 64'h8000_0000);
    check("wrap_instr", 64'(ifid_instr), 64'(rom_word(7'h7F)));
    check("wrap_rom_addr", 64'(rom_addr), 64'h0);

    // Asynchronous reset pulse with the queue full.
    repeat (4) tick();
    check("full_count", 64'(q_count), 64'd4);
    reset = 1'b0;
    #0.5;
    check("async_count", 64'(q_count), 64'h0);
    check("async_valid", 64'(ifid_valid), 64'h0);
    check("async_rom_addr", 64'(rom_addr), 64'h0);
    #0.5;
    reset = 1'b1;
    tick();
    check("post_rst_pc4", 64'(ifid_pc4), 64'h8000_0004);

    for (int i = 0; i < 10; i++) begin
      id_ready = (i % 3) != 0;
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
